// File: rtl/rgb2w_pkg.sv
// rtl/rgb2w_pkg.sv - shared GRB/GRBW field layout, FSM states and channel minimum helper
package rgb2w_pkg;

  localparam int COLOR_BITS    = 8;
  localparam int G_LSB         = 16;
  localparam int R_LSB         = 8;
  localparam int B_LSB         = 0;
  localparam int FRAME_END_BIT = 31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPT,
    ST_MIN,
    ST_SUB,
    ST_PRESENT
  } state_t;

  function automatic logic [COLOR_BITS-1:0] color_min(input logic [COLOR_BITS-1:0] a,
                                                      input logic [COLOR_BITS-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/rgb2w_conv_if.sv
// rtl/rgb2w_conv_if.sv - FIFO read port and GRBW output handshake of the converter
interface rgb2w_conv_if #(
  parameter int DATA_SIZE = 32
);

  logic                 in_rd_fifo_empty;
  logic [DATA_SIZE-1:0] in_rd_fifo_data;
  logic                 out_rd_fifo_en;
  logic [DATA_SIZE-1:0] out_word;
  logic                 out_frame_end;
  logic                 out_valid;
  logic                 in_ready;

  modport master (
    input  in_rd_fifo_empty,
    input  in_rd_fifo_data,
    input  in_ready,
    output out_rd_fifo_en,
    output out_word,
    output out_frame_end,
    output out_valid
  );

  modport slave (
    output in_rd_fifo_empty,
    output in_rd_fifo_data,
    output in_ready,
    input  out_rd_fifo_en,
    input  out_word,
    input  out_frame_end,
    input  out_valid
  );

endinterface

// File: rtl/rgb2w_conv.sv
// rtl/rgb2w_conv.sv - GRB to GRBW converter, white = min channel; RGB2W_SUBTRACT_EN removes W from colours
module rgb2w_conv #(
  parameter int DATA_SIZE  = 32,
  parameter int COLOR_BITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  rgb2w_conv_if.master     bus
);

  import rgb2w_pkg::*;

  localparam int PIX_BITS = 3 * COLOR_BITS;

  // Reset asserts asynchronously but releases only after two clean clock edges.
  logic [1:0] rst_sync;
  logic       rst_n_core;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n_core = rst_sync[1];

  logic [DATA_SIZE-1:0]  fifo_word;
  logic [6:0]            unused_fifo_bits;
  state_t                state;
  logic                  rd_en_q;
  logic                  mark_q;
  logic [PIX_BITS-1:0]   pix_q;
  logic [COLOR_BITS-1:0] m_q;
  logic [DATA_SIZE-1:0]  word_q;
  logic                  fe_q;
  logic                  valid_q;
  logic [COLOR_BITS-1:0] w_c, g_c, r_c, b_c;

  assign fifo_word        = bus.in_rd_fifo_data;
  assign unused_fifo_bits = fifo_word[30:24];

  always_comb begin
    w_c = color_min(m_q, pix_q[B_LSB +: COLOR_BITS]);
`ifdef RGB2W_SUBTRACT_EN
    g_c = pix_q[G_LSB +: COLOR_BITS] - w_c;
    r_c = pix_q[R_LSB +: COLOR_BITS] - w_c;
    b_c = pix_q[B_LSB +: COLOR_BITS] - w_c;
`else
    g_c = pix_q[G_LSB +: COLOR_BITS];
    r_c = pix_q[R_LSB +: COLOR_BITS];
    b_c = pix_q[B_LSB +: COLOR_BITS];
`endif
  end

  always_ff @(posedge clk or negedge rst_n_core) begin
    if (!rst_n_core) begin
      state   <= ST_IDLE;
      rd_en_q <= 1'b0;
      mark_q  <= 1'b0;
      pix_q   <= '0;
      m_q     <= '0;
      word_q  <= '0;
      fe_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!bus.in_rd_fifo_empty) begin
            state   <= ST_READ;
            rd_en_q <= 1'b1;
          end
        end
        ST_READ: begin
          rd_en_q <= 1'b0;
          state   <= ST_CAPT;
        end
        ST_CAPT: begin
          mark_q <= fifo_word[FRAME_END_BIT];
          pix_q  <= fifo_word[PIX_BITS-1:0];
          state  <= ST_MIN;
        end
        ST_MIN: begin
          m_q   <= color_min(pix_q[G_LSB +: COLOR_BITS], pix_q[R_LSB +: COLOR_BITS]);
          state <= ST_SUB;
        end
        ST_SUB: begin
          // A frame-end marker carries no colour, so its payload is forced to zero.
          word_q  <= mark_q ? '0 : {g_c, r_c, b_c, w_c};
          fe_q    <= mark_q;
          valid_q <= 1'b1;
          state   <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (bus.in_ready) begin
            valid_q <= 1'b0;
            if (!bus.in_rd_fifo_empty) begin
              state   <= ST_READ;
              rd_en_q <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_rd_fifo_en = rd_en_q;
  assign bus.out_word       = word_q;
  assign bus.out_frame_end  = fe_q;
  assign bus.out_valid      = valid_q;

endmodule
